// File: rtl/clock_fpga_pkg.sv
// Shared types and default timing constants for the clock/display input front end.
// The channel FSM and counter sizing here are shared by every pushbutton channel.
package clock_fpga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEF_NUM_BTN      = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC = 500_000;     // 10 ms
  localparam int unsigned DEF_HOLD_CYC     = 25_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_CYC   = 5_000_000;   // 0.1 s

  // One width serves both the debounce and hold/repeat counters of a channel.
  function automatic int unsigned cnt_width(input int unsigned db,
                                            input int unsigned hold,
                                            input int unsigned rep,
                                            input bit          use_repeat);
    int unsigned mx;
    mx = db;
    if (use_repeat) begin
      if (hold > mx) mx = hold;
      if (rep > mx)  mx = rep;
    end
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/pushbutton_conditioner_if.sv
// Button-side signal bundle: raw buttons and repeat permission in, conditioned strobes out.
// master = the board/display side, slave = the conditioner.
interface pushbutton_conditioner_if #(
  parameter int unsigned NUM_BTN = 4
);

  logic [NUM_BTN-1:0] btn_raw;
  logic               repeat_en;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_step;

  modport master (
    output btn_raw, repeat_en,
    input  btn_level, btn_press, btn_release, btn_step
  );

  modport slave (
    input  btn_raw, repeat_en,
    output btn_level, btn_press, btn_release, btn_step
  );

endinterface

// File: rtl/btn_channel.sv
// One pushbutton channel: 2-flop sync, debounce, press/release strobes and hold-to-repeat.
// Hold/repeat timing is built only when AUTO_REPEAT_EN is defined; otherwise btn_step == btn_release.
module btn_channel
  import clock_fpga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_step
);

`ifdef AUTO_REPEAT_EN
  localparam bit USE_REPEAT = 1'b1;
`else
  localparam bit USE_REPEAT = 1'b0;
`endif
  localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC, USE_REPEAT);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;
  btn_state_t       state_q, state_d;
  logic             rise, fall;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    db_cnt_d = '0;
    level_d  = level_q;
    // Any sample that agrees with the current level leaves the count cleared: bounces restart it.
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) level_d = ~level_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign rise      = level_d & ~level_q;
  assign fall      = ~level_d & level_q;
  assign press_d   = rise;
  assign release_d = fall;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             tick;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    tick       = 1'b0;
    case (state_q)
      IDLE: if (rise) state_d = HELD;
      HELD: begin
        if (fall) state_d = IDLE;
        else if (repeat_en) begin
          if (hold_cnt_q == HOLD_LAST) begin
            tick    = 1'b1;
            state_d = REPEAT;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (fall)                           state_d = IDLE;
        else if (!repeat_en)                state_d = HELD;  // re-arm full hold delay
        else if (hold_cnt_q == REPEAT_LAST) tick    = 1'b1;
        else                                hold_cnt_d = hold_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A release landing on a tick still yields a single step pulse.
  assign step_d = fall | tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  logic unused_repeat_en;
  assign unused_repeat_en = repeat_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = HELD;
      HELD:    if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign step_d = fall;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
      state_q   <= state_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_step    = step_q;

endmodule

// File: rtl/pushbutton_conditioner.sv
// Pushbutton front end for the clock time-set path: NUM_BTN independent btn_channel copies.
// Define AUTO_REPEAT_EN to enable hold-to-auto-repeat on btn_step.
module pushbutton_conditioner
  import clock_fpga_pkg::*;
#(
  parameter int unsigned NUM_BTN      = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input logic                     clk,
  input logic                     rst_n,
  pushbutton_conditioner_if.slave bus
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (bus.btn_raw[g]),
      .repeat_en   (bus.repeat_en),
      .btn_level   (bus.btn_level[g]),
      .btn_press   (bus.btn_press[g]),
      .btn_release (bus.btn_release[g]),
      .btn_step    (bus.btn_step[g])
    );
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Self-checking bench for pushbutton_conditioner: window-based behavioural model plus
// directed scenarios with hand-computed edge numbers (honours AUTO_REPEAT_EN).
module tb_pushbutton_conditioner;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int HC = 20;
  localparam int RC = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pushbutton_conditioner_if #(.NUM_BTN(NB)) bus ();

  pushbutton_conditioner #(
    .NUM_BTN      (NB),
    .DEBOUNCE_CYC (DB),
    .HOLD_CYC     (HC),
    .REPEAT_CYC   (RC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] is the raw value sampled k edges ago; the level flips once the synchronised
  // value (two edges late) has disagreed with it for DB consecutive edges.
  typedef struct packed {
    logic          lvl;
    logic [DB+1:0] hist;
    int            hold_start;
    logic          press;
    logic          rel;
    logic          step;
  } ch_model_t;

  ch_model_t mdl [NB];
  int        edge_n;

  function automatic ch_model_t model_next(input ch_model_t cur, input logic raw,
                                           input logic ren, input int now);
    ch_model_t nx;
    logic      flip;
    int        dt;
    nx       = cur;
    nx.hist  = {cur.hist[DB:0], raw};
    nx.press = 1'b0;
    nx.rel   = 1'b0;
    nx.step  = 1'b0;
    flip     = 1'b1;
    for (int k = 2; k < DB + 2; k++) if (nx.hist[k] == cur.lvl) flip = 1'b0;
    if (flip) begin
      nx.lvl        = ~cur.lvl;
      nx.press      = ~cur.lvl;
      nx.rel        = cur.lvl;
      nx.step       = cur.lvl;
      nx.hold_start = now;
    end else if (cur.lvl) begin
      // Hold timing is measured from the press or from the last edge repeat_en was low.
      if (!ren) nx.hold_start = now;
`ifdef AUTO_REPEAT_EN
      else begin
        dt = now - cur.hold_start;
        if (dt >= HC && ((dt - HC) % RC) == 0) nx.step = 1'b1;
      end
`else
      dt = 0;
`endif
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n <= 0;
      for (int i = 0; i < NB; i++) mdl[i] <= '0;
    end else begin
      edge_n <= edge_n + 1;
      for (int i = 0; i < NB; i++)
        mdl[i] <= model_next(mdl[i], bus.btn_raw[i], bus.repeat_en, edge_n + 1);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      check($sformatf("level[%0d]", i),   bus.btn_level[i],   mdl[i].lvl);
      check($sformatf("press[%0d]", i),   bus.btn_press[i],   mdl[i].press);
      check($sformatf("release[%0d]", i), bus.btn_release[i], mdl[i].rel);
      check($sformatf("step[%0d]", i),    bus.btn_step[i],    mdl[i].step);
    end
  end

  // ---------------- directed helpers ----------------
  int q_press[$];
  int q_rel[$];
  int q_step[$];
  int exp_q[$];

  task automatic clear_logs();
    q_press.delete();
    q_rel.delete();
    q_step.delete();
    exp_q.delete();
  endtask

  task automatic watch(input int ch, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (bus.btn_press[ch])   q_press.push_back(edge_n);
      if (bus.btn_release[ch]) q_rel.push_back(edge_n);
      if (bus.btn_step[ch])    q_step.push_back(edge_n);
    end
  endtask

  task automatic check_steps(input string name);
    check({name, "_count"}, q_step.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q_step.size(); i++)
      check($sformatf("%s_edge%0d", name, i), q_step[i], exp_q[i]);
  endtask

  // ---------------- stimulus ----------------
  int first_edge;
  int n_seen;
  int start;
  int p;
  logic [NB-1:0] pv;

  initial begin
    bus.btn_raw   = 4'hF;
    bus.repeat_en = 1'b0;

    // 1: reset with all buttons down, then simultaneous press
    repeat (3) @(negedge clk);
    check("t1_rst_level",   bus.btn_level,   0);
    check("t1_rst_press",   bus.btn_press,   0);
    check("t1_rst_release", bus.btn_release, 0);
    check("t1_rst_step",    bus.btn_step,    0);
    rst_n      = 1'b1;
    first_edge = -1;
    n_seen     = 0;
    pv         = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.btn_press != '0) begin
        n_seen++;
        if (first_edge < 0) begin
          first_edge = edge_n;
          pv         = bus.btn_press;
        end
      end
    end
    check("t1_press_edge",  first_edge, 6);
    check("t1_press_count", n_seen, 1);
    check("t1_press_value", pv, 4'hF);
    bus.btn_raw = 4'h0;
    repeat (10) @(negedge clk);
    check("t1_level_after_release", bus.btn_level, 4'h0);

    // 2: bouncing press on bit 0
    clear_logs();
    bus.btn_raw[0] = 1'b1; @(negedge clk);
    bus.btn_raw[0] = 1'b0; @(negedge clk);
    bus.btn_raw[0] = 1'b1; @(negedge clk);
    bus.btn_raw[0] = 1'b0; @(negedge clk);
    bus.btn_raw[0] = 1'b1;
    start = edge_n;
    watch(0, 10);
    check("t2_press_count", q_press.size(), 1);
    if (q_press.size() > 0) check("t2_press_edge", q_press[0], start + 6);
    bus.btn_raw[0] = 1'b0;
    watch(0, 10);
    check("t2_release_count", q_rel.size(), 1);

    // 3: short press on bit 1, repeat allowed but never reached
    clear_logs();
    bus.repeat_en  = 1'b1;
    bus.btn_raw[1] = 1'b1;
    start = edge_n;
    watch(1, 10);
    bus.btn_raw[1] = 1'b0;
    watch(1, 12);
    check("t3_press_count",   q_press.size(), 1);
    check("t3_release_count", q_rel.size(), 1);
    exp_q.push_back(start + 16);
    check_steps("t3_step");

    // 4: long hold on bit 2, level held 50 cycles past press
    clear_logs();
    bus.btn_raw[2] = 1'b1;
    start = edge_n;
    p     = start + 6;
    watch(2, 6 + 44);
    bus.btn_raw[2] = 1'b0;
    watch(2, 12);
    check("t4_press_count", q_press.size(), 1);
    if (q_press.size() > 0) check("t4_press_edge", q_press[0], p);
`ifdef AUTO_REPEAT_EN
    exp_q.push_back(p + 20);
    exp_q.push_back(p + 28);
    exp_q.push_back(p + 36);
    exp_q.push_back(p + 44);
`endif
    exp_q.push_back(p + 50);
    check_steps("t4_step");

    // 5: repeat_en drops during repeat and comes back; hold delay restarts
    clear_logs();
    bus.btn_raw[3] = 1'b1;
    start = edge_n;
    p     = start + 6;
    watch(3, 6 + 24);
    bus.repeat_en = 1'b0;
    watch(3, 6);
    bus.repeat_en = 1'b1;
    watch(3, 24);
    bus.btn_raw[3] = 1'b0;
    watch(3, 10);
`ifdef AUTO_REPEAT_EN
    exp_q.push_back(p + 20);
    exp_q.push_back(p + 50);
    exp_q.push_back(p + 58);
`endif
    exp_q.push_back(p + 60);
    check_steps("t5_step");

    // 7: reset while bit 0 is held -> no release, fresh press after reset
    clear_logs();
    bus.btn_raw[0] = 1'b1;
    watch(0, 8);
    check("t7_level_before_reset", bus.btn_level[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_level_in_reset", bus.btn_level, 4'h0);
    watch(0, 2);
    check("t7_no_release_in_reset", q_rel.size(), 0);
    rst_n = 1'b1;
    clear_logs();
    watch(0, 10);
    check("t7_press_count", q_press.size(), 1);
    if (q_press.size() > 0) check("t7_press_edge", q_press[0], 6);
    check("t7_release_count", q_rel.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
